// File: rtl/serial_subtractor_pkg.sv
// Shared constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_subtractor_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_fullsubtractor.sv
// One-bit full subtractor: d = a - b - bin, bout is the borrow-out.
// Ports: a, b, bin in; d, bout out. Purely combinational.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock.
// Ports: clk, rst_n, in_valid/in_ready + a/b in, out_valid/out_ready + diff/borrow out.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             bin_q;
  logic             borrow_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             d;
  logic             bout;
  logic             accept;

  fullsubtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bin_q),
    .d    (d),
    .bout (bout)
  );

  assign accept = in_valid & in_ready_q;
  // New bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
  assign res_d  = {d, res_q[WIDTH-1:1]};

  // diff_q/borrow_q are only loaded on completion so the visible
  // result never shows the partially shifted value during RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      diff_q      <= '0;
      cnt_q       <= '0;
      bin_q       <= 1'b0;
      borrow_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            a_q        <= a;
            b_q        <= b;
            bin_q      <= 1'b0;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          bin_q <= bout;
          if (cnt_q == LAST) begin
            cnt_q       <= '0;
            diff_q      <= res_d;
            borrow_q    <= bout;
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 8, 2 and 16.
// Expected results are queued at issue and compared on each handshake.
module tb_serial_subtractor;
  import serial_subtractor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  int          w = WIDTH_DEFAULT;

  always #5 clk = ~clk;

  logic iv8, iv2, iv16;
  logic ir8, ir2, ir16;
  logic ov8, ov2, ov16;
  logic bw8, bw2, bw16;
  logic [7:0]  d8;
  logic [1:0]  d2;
  logic [15:0] d16;

  assign iv8  = in_valid && (w == 8);
  assign iv2  = in_valid && (w == 2);
  assign iv16 = in_valid && (w == 16);

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
    .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .diff(d8), .borrow(bw8));

  serial_subtractor #(.WIDTH(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv2), .in_ready(ir2),
    .a(a[1:0]), .b(b[1:0]), .out_valid(ov2), .out_ready(out_ready),
    .diff(d2), .borrow(bw2));

  serial_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
    .a(a[15:0]), .b(b[15:0]), .out_valid(ov16), .out_ready(out_ready),
    .diff(d16), .borrow(bw16));

  logic        ir, ov, bw;
  logic [31:0] df;

  always_comb begin
    ir = ir8;
    ov = ov8;
    bw = bw8;
    df = {24'd0, d8};
    case (w)
      2: begin
        ir = ir2; ov = ov2; bw = bw2; df = {30'd0, d2};
      end
      16: begin
        ir = ir16; ov = ov16; bw = bw16; df = {16'd0, d16};
      end
      default: ;
    endcase
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [32:0] sb[$];

  function automatic logic [32:0] model(int ww, logic [31:0] x, logic [31:0] y);
    logic [31:0] m, xm, ym;
    m  = 32'hFFFF_FFFF >> (32 - ww);
    xm = x & m;
    ym = y & m;
    return {xm < ym, (xm - ym) & m};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] x, input logic [31:0] y);
    int k;
    k = 0;
    in_valid = 1'b1;
    a = x;
    b = y;
    while (!ir && k < 200) begin
      step();
      k++;
    end
    if (!ir) begin
      n_chk++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready got 0 required 1");
    end
    sb.push_back(model(w, x, y));
    step();
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic test_reset();
    int wl[3];
    wl = '{8, 2, 16};
    rst_n = 1'b0;
    step();
    step();
    for (int i = 0; i < 3; i++) begin
      w = wl[i];
      #1;
      n_chk++;
      if ({ir, ov, bw, df} !== 35'd0) begin
        n_fail++;
        $display("FAIL reset_w%0d: got ir=%b ov=%b bw=%b df=%h required all 0",
                 w, ir, ov, bw, df);
      end
    end
    w = 8;
    step();
    rst_n = 1'b1;
    step();
    n_chk++;
    if (ir !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready: got %b required 1", ir);
    end
  endtask

  task automatic test_basic(input logic [31:0] x, input logic [31:0] y);
    int lat;
    logic [32:0] e;
    out_ready = 1'b1;
    issue(x, y);
    lat = 0;
    while (!ov && lat < w + 10) begin
      step();
      lat++;
    end
    n_chk++;
    if (lat !== w) begin
      n_fail++;
      $display("FAIL basic_latency_w%0d: got %0d required %0d", w, lat, w);
    end
    e = sb.pop_front();
    n_chk++;
    if ({bw, df} !== e) begin
      n_fail++;
      $display("FAIL basic_result_w%0d: got %b/%h required %b/%h",
               w, bw, df, e[32], e[31:0]);
    end
    step();
    n_chk++;
    if (ov !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_one_cycle_w%0d: out_valid got %b required 0", w, ov);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] xa[4];
    logic [31:0] ya[4];
    logic [32:0] e;
    int k;
    xa = '{32'h00, 32'hFF, 32'h00, 32'h37};
    ya = '{32'h01, 32'hFF, 32'hFF, 32'h37};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      issue(xa[i], ya[i]);
      k = 0;
      while (!ov && k < w + 10) begin
        step();
        k++;
      end
      e = sb.pop_front();
      n_chk++;
      if (!ov || {bw, df} !== e) begin
        n_fail++;
        $display("FAIL boundary_%0d: got ov=%b %b/%h required 1 %b/%h",
                 i, ov, bw, df, e[32], e[31:0]);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [32:0] e;
    int k;
    int seen;
    out_ready = 1'b0;
    issue(32'h80, 32'h7F);
    e = sb.pop_front();
    k = 0;
    while (!ov && k < w + 10) begin
      step();
      k++;
    end
    in_valid = 1'b1;
    a = 32'h33;
    b = 32'h11;
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if (ov !== 1'b1 || ir !== 1'b0 || {bw, df} !== e) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got ov=%b ir=%b %b/%h required 1 0 %b/%h",
                 i, ov, ir, bw, df, e[32], e[31:0]);
      end
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    n_chk++;
    if (ov !== 1'b0 || ir !== 1'b1 || {bw, df} !== e) begin
      n_fail++;
      $display("FAIL bp_release: got ov=%b ir=%b %b/%h required 0 1 %b/%h",
               ov, ir, bw, df, e[32], e[31:0]);
    end
    seen = 0;
    for (int i = 0; i < w + 4; i++) begin
      step();
      if (ov) seen++;
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL bp_ignored_pulse: out_valid cycles got %0d required 0", seen);
    end
  endtask

  task automatic test_reset_mid_run();
    int seen;
    out_ready = 1'b1;
    issue(32'h5A, 32'h23);
    sb.delete();
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ir, ov, bw, df} !== 35'd0) begin
      n_fail++;
      $display("FAIL midrun_reset: got ir=%b ov=%b bw=%b df=%h required all 0",
               ir, ov, bw, df);
    end
    step();
    rst_n = 1'b1;
    step();
    n_chk++;
    if (ir !== 1'b1) begin
      n_fail++;
      $display("FAIL midrun_release_ready: got %b required 1", ir);
    end
    seen = 0;
    for (int i = 0; i < w + 4; i++) begin
      if (ov) seen++;
      step();
    end
    n_chk++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midrun_no_output: out_valid cycles got %0d required 0", seen);
    end
    test_basic(32'h10, 32'h01);
  endtask

  task automatic test_random(input int n);
    int seen;
    sb.delete();
    fork
      begin
        for (int i = 0; i < n; i++) begin
          in_valid = 1'b0;
          repeat ($urandom_range(0, 3)) step();
          issue($urandom, $urandom);
        end
        in_valid = 1'b0;
      end
      begin
        int got;
        int cyc;
        logic [32:0] e;
        got = 0;
        cyc = 0;
        while (got < n && cyc < n * (w + 8) * 6) begin
          out_ready = ($urandom_range(0, 3) != 0);
          if (ov && out_ready) begin
            n_chk++;
            if (sb.size() == 0) begin
              n_fail++;
              $display("FAIL rand_extra_w%0d: got %b/%h required none", w, bw, df);
            end else begin
              e = sb.pop_front();
              if ({bw, df} !== e) begin
                n_fail++;
                $display("FAIL rand_result_w%0d_%0d: got %b/%h required %b/%h",
                         w, got, bw, df, e[32], e[31:0]);
              end
            end
            got++;
          end
          step();
          cyc++;
        end
        n_chk++;
        if (got !== n) begin
          n_fail++;
          $display("FAIL rand_count_w%0d: got %0d required %0d", w, got, n);
        end
      end
    join
    out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < w + 4; i++) begin
      if (ov) seen++;
      step();
    end
    n_chk++;
    if (seen !== 0 || sb.size() !== 0) begin
      n_fail++;
      $display("FAIL rand_leftover_w%0d: got ov=%0d q=%0d required 0 0",
               w, seen, sb.size());
    end
  endtask

  initial begin
    test_reset();
    w = 8;
    test_basic(32'h5A, 32'h23);
    test_boundary();
    test_backpressure();
    test_reset_mid_run();
    test_random(1000);
    w = 2;
    test_basic(32'h5A, 32'h23);
    test_basic(32'h0, 32'h3);
    test_random(300);
    w = 16;
    test_basic(32'h5A, 32'h23);
    test_basic(32'h00A0, 32'hF123);
    test_random(300);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time got 900000 required less");
    $fatal(1, "timeout");
  end

endmodule
